pipeline_hazard_ctrl: RTL

Hazard and stall controller for the 5-stage LC-3b pipeline. It drives the load enables and bubble/flush selects that the IF/ID, ID/EX, EX/MEM and MEM/WB registers consume. It keeps a scoreboard of in-flight destination registers and detects RAW and load-use hazards from ID-stage source numbers. It freezes the pipe on memory waits, squashes wrong-path instructions on taken branches, and generates registered forwarding selects for the EX stage.

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// LC-3b 5-stage hazard/stall controller: scoreboard, stalls, flush, fwd selects.
// Optional build macro FORWARDING_EN enables EX operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [2:0]             id_sr1_num,
    input  logic [2:0]             id_sr2_num,
    input  logic                   id_uses_sr1,
    input  logic                   id_uses_sr2,
    input  logic [2:0]             id_dest,
    input  logic                   id_writes_reg,
    input  logic                   id_is_load,
    input  logic                   ex_branch_taken,
    input  logic                   mem_stall,
    output logic                   pc_load,
    output logic                   if_id_load,
    output logic                   id_ex_load,
    output logic                   ex_mem_load,
    output logic                   mem_wb_load,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic [1:0]             ex_fwd_sel1,
    output logic [1:0]             ex_fwd_sel2,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
        logic       is_load;
    } sb_t;

    sb_t ex_q, mem_q, wb_q, id_e;

    function automatic logic hit(input sb_t e, input logic [2:0] src,
                                 input logic used);
        return e.valid && used && (e.dest == src);
    endfunction

    logic ex1, ex2, mem1, mem2;
    logic hazard, flush, stall;

    assign ex1  = hit(ex_q, id_sr1_num, id_uses_sr1);
    assign ex2  = hit(ex_q, id_sr2_num, id_uses_sr2);
    assign mem1 = hit(mem_q, id_sr1_num, id_uses_sr1);
    assign mem2 = hit(mem_q, id_sr2_num, id_uses_sr2);

`ifdef FORWARDING_EN
    assign hazard = id_valid && ex_q.is_load && (ex1 || ex2);
`else
    logic wb1, wb2;
    assign wb1    = hit(wb_q, id_sr1_num, id_uses_sr1);
    assign wb2    = hit(wb_q, id_sr2_num, id_uses_sr2);
    assign hazard = id_valid && (ex1 || ex2 || mem1 || mem2 || wb1 || wb2);
`endif

    assign flush = !mem_stall && ex_branch_taken;
    assign stall = !mem_stall && !ex_branch_taken && hazard;

    assign id_e.valid   = id_valid && id_writes_reg;
    assign id_e.dest    = id_dest;
    assign id_e.is_load = id_is_load;

    always_comb begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_load   = 1'b1;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (!reset_n) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            mem_wb_load  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (mem_stall) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            mem_wb_load  = 1'b0;
        end else if (flush) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (stall) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_stall) begin
            ex_q  <= (flush || stall) ? sb_t'('0) : id_e;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if ((mem_stall || stall) && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

`ifdef FORWARDING_EN
    function automatic logic [1:0] sel_of(input logic e, input logic m);
        return e ? 2'd1 : (m ? 2'd2 : 2'd0);
    endfunction

    // Selects describe the instruction entering EX, so they move with ID/EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_fwd_sel1 <= 2'd0;
            ex_fwd_sel2 <= 2'd0;
        end else if (!mem_stall) begin
            if (flush || stall || !id_valid) begin
                ex_fwd_sel1 <= 2'd0;
                ex_fwd_sel2 <= 2'd0;
            end else begin
                ex_fwd_sel1 <= sel_of(ex1, mem1);
                ex_fwd_sel2 <= sel_of(ex2, mem2);
            end
        end
    end
`else
    assign ex_fwd_sel1 = 2'd0;
    assign ex_fwd_sel2 = 2'd0;
`endif

    logic unused_ok;
    assign unused_ok = ^{ex_q.is_load, mem_q.is_load, wb_q, mem1, mem2};

endmodule
